// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported line-wide memory between I-side refills and D-side refills/writes.
// D-side has priority; a starvation counter forces an I grant after STARVE_LIMIT D grants.
module mem_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned LINE_BITS    = 128,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_req,
    input  logic [ADDR_W-1:0]    i_addr,
    output logic [LINE_BITS-1:0] i_rdata,
    output logic                 i_done,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [ADDR_W-1:0]    d_addr,
    input  logic [LINE_BITS-1:0] d_wdata,
    output logic [LINE_BITS-1:0] d_rdata,
    output logic                 d_done,
    output logic                 mem_valid,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [LINE_BITS-1:0] mem_wdata,
    input  logic [LINE_BITS-1:0] mem_rdata,
    input  logic                 mem_ready,
    output logic                 busy
);

    localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {StIdle, StBusyI, StBusyD, StDone} state_e;

    state_e               state_q, state_d;
    logic [3:0]           starve_q, starve_d;
    logic                 mem_valid_q, mem_valid_d;
    logic                 mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [LINE_BITS-1:0] mem_wdata_q, mem_wdata_d;
    logic [LINE_BITS-1:0] i_rdata_q, i_rdata_d;
    logic [LINE_BITS-1:0] d_rdata_q, d_rdata_d;
    logic                 i_done_q, i_done_d;
    logic                 d_done_q, d_done_d;
    logic                 busy_q, busy_d;
    logic                 i_elig, d_elig;

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        mem_valid_d = mem_valid_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_done_d    = 1'b0;
        d_done_d    = 1'b0;
        // A request still high on its own done cycle is stale and must not win.
        i_elig      = i_req && !i_done_q;
        d_elig      = d_req && !d_done_q;

        unique case (state_q)
            StIdle: begin
                if (d_elig && !(i_elig && starve_q == Limit)) begin
                    state_d     = StBusyD;
                    mem_valid_d = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    if (i_req && starve_q != Limit) starve_d = starve_q + 4'd1;
                end else if (i_elig) begin
                    state_d     = StBusyI;
                    mem_valid_d = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = i_addr;
                    mem_wdata_d = '0;
                    starve_d    = '0;
                end
                if (!i_req) starve_d = '0;
            end
            StBusyI: begin
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    i_rdata_d   = mem_rdata;
                    i_done_d    = 1'b1;
                    state_d     = StDone;
                end
            end
            StBusyD: begin
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    if (!mem_we_q) d_rdata_d = mem_rdata;
                    d_done_d    = 1'b1;
                    state_d     = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            starve_q    <= '0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            mem_valid_q <= mem_valid_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_done_q    <= i_done_d;
            d_done_q    <= d_done_d;
            busy_q      <= busy_d;
        end
    end

    assign mem_valid = mem_valid_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_done    = i_done_q;
    assign d_done    = d_done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a table of single transactions plus hand-written
// sequences for priority, starvation, idle mem_ready and async reset mid-transfer.
module tb_mem_arbiter;

    logic         clock, reset;
    logic         i_req, d_req, d_we, mem_ready;
    logic [31:0]  i_addr, d_addr, mem_addr;
    logic [127:0] d_wdata, mem_rdata, i_rdata, d_rdata, mem_wdata;
    logic         i_done, d_done, mem_valid, mem_we, busy;

    int n_vec = 0;
    int n_miss = 0;
    int i_done_cnt = 0;
    int d_done_cnt = 0;

    mem_arbiter #(.ADDR_W(32), .LINE_BITS(128), .STARVE_LIMIT(4)) dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .busy(busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(negedge clock) begin
        if (i_done === 1'b1) i_done_cnt++;
        if (d_done === 1'b1) d_done_cnt++;
    end

    typedef struct {
        logic         side_d;
        logic         we;
        logic [31:0]  addr;
        logic [127:0] wdata;
        logic [127:0] rdata;
        int           delay;
        logic         exp_we;
        logic [127:0] exp_wdata;
        logic [127:0] exp_i_rdata;
        logic [127:0] exp_d_rdata;
    } txn_t;

    txn_t        tbl [5];
    logic [31:0] starve_exp [6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic run_txn(input txn_t t, input int idx);
        string p;
        p = $sformatf("v%0d_", idx);
        if (t.side_d) begin
            d_req = 1'b1; d_we = t.we; d_addr = t.addr; d_wdata = t.wdata;
        end else begin
            i_req = 1'b1; i_addr = t.addr;
        end
        @(negedge clock);
        chk({p, "grant_valid"}, mem_valid, 1);
        chk({p, "grant_busy"}, busy, 1);
        chk({p, "grant_addr"}, mem_addr, t.addr);
        chk({p, "grant_we"}, mem_we, t.exp_we);
        chk({p, "grant_wdata"}, mem_wdata, t.exp_wdata);
        repeat (t.delay) @(negedge clock);
        if (t.delay > 0) chk({p, "valid_held"}, mem_valid, 1);
        mem_ready = 1'b1;
        mem_rdata = t.rdata;
        @(negedge clock);
        chk({p, "i_done"}, i_done, !t.side_d);
        chk({p, "d_done"}, d_done, t.side_d);
        chk({p, "valid_drop"}, mem_valid, 0);
        chk({p, "i_rdata"}, i_rdata, t.exp_i_rdata);
        chk({p, "d_rdata"}, d_rdata, t.exp_d_rdata);
        i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
        @(negedge clock);
        chk({p, "done_clear"}, {i_done, d_done}, 0);
        chk({p, "idle_busy"}, busy, 0);
    endtask

    initial begin
        int bi, bd;
        tbl[0] = '{1'b0, 1'b0, 32'h100, 128'h0, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210, 3,
                   1'b0, 128'h0, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210, 128'h0};
        tbl[1] = '{1'b1, 1'b1, 32'h200, 128'hdead_beef_0000_1111_2222_3333_4444_5555,
                   {4{32'h5a5a_5a5a}}, 1, 1'b1, 128'hdead_beef_0000_1111_2222_3333_4444_5555,
                   128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210, 128'h0};
        tbl[2] = '{1'b1, 1'b0, 32'h300, 128'h0, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 0,
                   1'b0, 128'h0, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210,
                   128'h1111_2222_3333_4444_5555_6666_7777_8888};
        tbl[3] = '{1'b1, 1'b1, 32'h340, {4{32'hc0ff_ee00}}, {4{32'h5a5a_5a5a}}, 2,
                   1'b1, {4{32'hc0ff_ee00}}, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210,
                   128'h1111_2222_3333_4444_5555_6666_7777_8888};
        tbl[4] = '{1'b0, 1'b0, 32'h180, 128'h0, {4{32'h0bad_f00d}}, 1,
                   1'b0, 128'h0, {4{32'h0bad_f00d}}, 128'h1111_2222_3333_4444_5555_6666_7777_8888};
        starve_exp = '{32'h500, 32'h500, 32'h500, 32'h500, 32'h600, 32'h500};

        reset = 1'b1; i_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        #2 reset = 1'b0;
        #1;
        chk("rst_ctrl", {mem_valid, mem_we, i_done, d_done, busy}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_data", mem_wdata | i_rdata | d_rdata, 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        bd = d_done_cnt;
        for (int k = 0; k < 5; k++) begin
            run_txn(tbl[k], k);
            if (k == 0) chk("v0_no_d_done", d_done_cnt - bd, 0);
        end

        // Simultaneous requests: D write first, then I in the following IDLE.
        bi = i_done_cnt; bd = d_done_cnt;
        i_req = 1; i_addr = 32'h400;
        d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = {4{32'h1234_5678}};
        @(negedge clock);
        chk("both_first_addr", mem_addr, 32'h200);
        chk("both_first_we", mem_we, 1);
        chk("both_first_wdata", mem_wdata, {4{32'h1234_5678}});
        mem_ready = 1;
        @(negedge clock);
        chk("both_d_done", {i_done, d_done}, 2'b01);
        d_req = 0; mem_ready = 0;
        @(negedge clock);
        @(negedge clock);
        chk("both_second_valid", mem_valid, 1);
        chk("both_second_addr", mem_addr, 32'h400);
        chk("both_second_we", mem_we, 0);
        chk("both_second_wdata", mem_wdata, 0);
        mem_ready = 1; mem_rdata = {4{32'hfeed_face}};
        @(negedge clock);
        chk("both_i_rdata", i_rdata, {4{32'hfeed_face}});
        i_req = 0; mem_ready = 0;
        repeat (2) @(negedge clock);
        chk("both_i_once", i_done_cnt - bi, 1);
        chk("both_d_once", d_done_cnt - bd, 1);

        // mem_ready while idle must be ignored.
        mem_ready = 1;
        repeat (2) begin
            @(negedge clock);
            chk("idle_ready", {mem_valid, busy, i_done, d_done}, 0);
        end
        mem_ready = 0;

        // Both held: four D grants, one forced I grant, then D again (counter cleared).
        i_req = 1; i_addr = 32'h600; d_req = 1; d_we = 0; d_addr = 32'h500;
        for (int g = 0; g < 6; g++) begin
            int w;
            w = 0;
            while (mem_valid !== 1'b1 && w < 10) begin
                @(negedge clock);
                w++;
            end
            if (mem_valid !== 1'b1) begin
                chk($sformatf("starve_g%0d_timeout", g), mem_valid, 1);
                break;
            end
            chk($sformatf("starve_g%0d_addr", g), mem_addr, starve_exp[g]);
            mem_ready = 1; mem_rdata = {4{32'h0}} | 128'(g);
            @(negedge clock);
            mem_ready = 0;
            if (starve_exp[g] == 32'h600) chk($sformatf("starve_g%0d_done", g), i_done, 1);
            else chk($sformatf("starve_g%0d_done", g), d_done, 1);
            @(negedge clock);
        end
        i_req = 0; d_req = 0;
        repeat (2) @(negedge clock);

        // Async reset in the middle of a D transfer.
        d_req = 1; d_we = 0; d_addr = 32'h700;
        @(negedge clock);
        chk("rstmid_valid", mem_valid, 1);
        #2 reset = 1'b0;
        #1;
        chk("rstmid_ctrl", {mem_valid, mem_we, i_done, d_done, busy}, 0);
        chk("rstmid_addr", mem_addr, 0);
        chk("rstmid_data", i_rdata | d_rdata | mem_wdata, 0);
        @(negedge clock);
        chk("rstmid_held", mem_valid, 0);
        reset = 1'b1;
        @(negedge clock);
        chk("rstmid_regrant_valid", mem_valid, 1);
        chk("rstmid_regrant_addr", mem_addr, 32'h700);
        mem_ready = 1; mem_rdata = {4{32'h7777_0001}};
        @(negedge clock);
        chk("rstmid_d_done", d_done, 1);
        chk("rstmid_d_rdata", d_rdata, {4{32'h7777_0001}});
        d_req = 0; mem_ready = 0;
        @(negedge clock);
        chk("rstmid_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
